traffic_light_controller_n: RTL and testbench
=============================================

Name: traffic_light_controller_n

Overview:
- Parametrised successor to the two-road traffic light system: N-direction round-robin controller with sensor-driven arbitration.
- Adds minimum and maximum green times, an all-red clearance interval and a flashing-yellow maintenance mode.
- Sits between the road sensor inputs and the lamp drivers. Outputs are Moore, decoded from registered state only.

Parameters:
- N_DIR, 2, number of directions (2..8).
- MIN_GREEN, 4, minimum green cycles before any handover.
- MAX_GREEN, 12, green cycles after which a handover is forced if another direction requests; must be >= MIN_GREEN.
- YELLOW_CYC, 5, yellow duration in cycles (>=1).
- ALL_RED_CYC, 1, all-red clearance in cycles; 0 skips the ALL_RED state.
- FLASH_HALF, 2, half-period of the flashing yellow in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s  in  N_DIR  per-direction traffic sensor, 1 = vehicle waiting.
- flash  in  1  maintenance mode request, level-sensitive.
- L  out  3*N_DIR  lamps; slice [3i+2:3i] is direction i; 3'b001 green, 3'b010 yellow, 3'b100 red, 3'b000 dark.
- active_dir  out  $clog2(N_DIR)  direction currently owning green/yellow.
- phase  out  2  0 GREEN, 1 YELLOW, 2 ALL_RED, 3 FLASH.

Behaviour:
- Reset (reset=0, asynchronous) forces: state GREEN, cur=0, nxt=0, timer=0, flash_ph=0.
  - Outputs during and after reset: L = dir0 green, all other directions red; active_dir=0; phase=0.
- timer counts cycles spent in the current state. It clears on every state change. In GREEN it saturates at MAX_GREEN-1.
- "other" = OR of s[j] for all j != cur.
- GREEN, leaving at a clock edge:
  - If flash=1 and timer >= MIN_GREEN-1: go to YELLOW with nxt=cur.
  - Else if timer >= MIN_GREEN-1 and other=1 and (s[cur]=0 or timer == MAX_GREEN-1): go to YELLOW.
    - nxt = first j with s[j]=1, searching cur+1, cur+2, ... modulo N_DIR.
    - nxt is latched on this edge; later changes to s do not alter it.
  - Otherwise stay in GREEN. With no competing request, green is held indefinitely.
- YELLOW: cur lamp is yellow, all others red. After YELLOW_CYC cycles go to ALL_RED, or straight to the post-clearance target if ALL_RED_CYC=0.
- ALL_RED: all lamps red. After ALL_RED_CYC cycles:
  - if flash=1, go to FLASH;
  - else go to GREEN with cur=nxt.
- FLASH: every lamp shows 3'b010 when flash_ph=1 and 3'b000 when flash_ph=0.
  - flash_ph toggles every FLASH_HALF cycles and is 1 on FLASH entry.
  - When flash=0 is sampled: go to ALL_RED with nxt=cur.
  - On exit from ALL_RED the controller resumes GREEN on the same cur.
- active_dir = cur in every state.
- s and flash are synchronous inputs sampled only at rising edges. There is no input synchroniser inside the block.
- Width rules:
  - timer width is $clog2 of the largest of MAX_GREEN, YELLOW_CYC, ALL_RED_CYC+1 and FLASH_HALF, plus 1.
  - The round-robin index wraps modulo N_DIR, including for non-power-of-two N_DIR.
- Reset asserted mid-operation (any state) returns immediately to the reset values. No clearance interval is enforced on reset.

Test Plan:
- Defaults; reset, then s=2'b01 for 40 cycles -> L=6'b100_001, active_dir=0, phase=0 throughout.
- Defaults; s=2'b10 from reset release -> dir0 green for 4 cycles, yellow for 5 (L=6'b100_010), all-red for 1 (6'b100_100), then L=6'b001_100 with active_dir=1 from the 11th cycle.
- Defaults; s=2'b11 held -> greens alternate, each 12 cycles, full period 36 cycles; no green ever exceeds 12 cycles.
- N_DIR=3; cur=0 green; s=3'b101 -> handover skips dir1 and L shows dir2 green; then s=3'b011 -> next green goes to dir0 (wrap-around).
- Defaults; flash=1 in GREEN at timer=1:
  - yellow starts only after MIN_GREEN is satisfied, then 1 all-red cycle;
  - then all lamps alternate 010/000 every 2 cycles;
  - flash=0 -> 1 all-red cycle, then green resumes on the same direction.
- Defaults; reset pulsed low for 1 ns during YELLOW of dir1 -> L=6'b100_001, phase=0 and active_dir=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/traffic_light_controller_n.sv
// N-direction round-robin traffic light controller with sensor arbitration,
// min/max green, all-red clearance and flashing-yellow maintenance mode.
module traffic_light_controller_n #(
   parameter int N_DIR       = 2,
   parameter int MIN_GREEN   = 4,
   parameter int MAX_GREEN   = 12,
   parameter int YELLOW_CYC  = 5,
   parameter int ALL_RED_CYC = 1,
   parameter int FLASH_HALF  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_DIR-1:0]         s,
   input  logic                     flash,
   output logic [3*N_DIR-1:0]       L,
   output logic [$clog2(N_DIR)-1:0] active_dir,
   output logic [1:0]               phase
);

   localparam int CW   = $clog2(N_DIR);
   localparam int M01  = (MAX_GREEN > YELLOW_CYC) ? MAX_GREEN : YELLOW_CYC;
   localparam int M23  = ((ALL_RED_CYC + 1) > FLASH_HALF) ? (ALL_RED_CYC + 1) : FLASH_HALF;
   localparam int TMAX = (M01 > M23) ? M01 : M23;
   localparam int TW   = $clog2(TMAX) + 1;

   localparam logic [TW-1:0] MIN_T = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] MAX_T = TW'(MAX_GREEN - 1);
   localparam logic [TW-1:0] YEL_T = TW'(YELLOW_CYC - 1);
   localparam logic [TW-1:0] AR_T  = TW'((ALL_RED_CYC > 0) ? ALL_RED_CYC - 1 : 0);
   localparam logic [TW-1:0] FH_T  = TW'(FLASH_HALF - 1);
   localparam logic [3*N_DIR-1:0] RST_L = {{(N_DIR-1){3'b100}}, 3'b001};

   typedef enum logic [1:0] {
      ST_GREEN   = 2'd0,
      ST_YELLOW  = 2'd1,
      ST_ALL_RED = 2'd2,
      ST_FLASH   = 2'd3
   } state_t;

   state_t            state, state_d;
   logic [CW-1:0]     cur, cur_d, nxt, nxt_d, pick;
   logic [TW-1:0]     timer, timer_d;
   logic              fph, fph_d, found;
   int unsigned       sum;
   logic [3*N_DIR-1:0] l_d;

   // Round-robin search from cur+1; found doubles as "another direction requests".
   always_comb begin
      found = 1'b0;
      pick  = cur;
      sum   = 0;
      for (int unsigned k = 1; k < N_DIR; k++) begin
         sum = k + 32'(cur);
         if (sum >= N_DIR) sum = sum - N_DIR;
         if (!found && s[CW'(sum)]) begin
            found = 1'b1;
            pick  = CW'(sum);
         end
      end
   end

   always_comb begin
      state_d = state;
      cur_d   = cur;
      nxt_d   = nxt;
      fph_d   = fph;
      timer_d = timer + 1'b1;
      case (state)
         ST_GREEN: begin
            if (timer == MAX_T) timer_d = timer;
            // A flash request hands over to the same direction once min green is met.
            if (timer >= MIN_T && (flash || (found && (!s[cur] || timer == MAX_T)))) begin
               state_d = ST_YELLOW;
               timer_d = '0;
               nxt_d   = flash ? cur : pick;
            end
         end
         ST_YELLOW: begin
            if (timer == YEL_T) begin
               timer_d = '0;
               if (ALL_RED_CYC > 0) begin
                  state_d = ST_ALL_RED;
               end else if (flash) begin
                  state_d = ST_FLASH;
                  fph_d   = 1'b1;
               end else begin
                  state_d = ST_GREEN;
                  cur_d   = nxt;
               end
            end
         end
         ST_ALL_RED: begin
            if (timer == AR_T) begin
               timer_d = '0;
               if (flash) begin
                  state_d = ST_FLASH;
                  fph_d   = 1'b1;
               end else begin
                  state_d = ST_GREEN;
                  cur_d   = nxt;
               end
            end
         end
         ST_FLASH: begin
            if (!flash) begin
               timer_d = '0;
               nxt_d   = cur;
               state_d = (ALL_RED_CYC > 0) ? ST_ALL_RED : ST_GREEN;
            end else if (timer == FH_T) begin
               timer_d = '0;
               fph_d   = ~fph;
            end
         end
         default: ;
      endcase
   end

   function automatic logic [2:0] lamp(state_t st, logic own, logic ph);
      case (st)
         ST_GREEN:   lamp = own ? 3'b001 : 3'b100;
         ST_YELLOW:  lamp = own ? 3'b010 : 3'b100;
         ST_ALL_RED: lamp = 3'b100;
         default:    lamp = ph ? 3'b010 : 3'b000;
      endcase
   endfunction

   for (genvar i = 0; i < N_DIR; i++) begin : g_lamp
      assign l_d[3*i +: 3] = lamp(state_d, cur_d == CW'(i), fph_d);
   end

   // Outputs are registered from the next-state decode so they track state exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_GREEN;
         cur        <= '0;
         nxt        <= '0;
         timer      <= '0;
         fph        <= 1'b0;
         L          <= RST_L;
         active_dir <= '0;
         phase      <= 2'd0;
      end else begin
         state      <= state_d;
         cur        <= cur_d;
         nxt        <= nxt_d;
         timer      <= timer_d;
         fph        <= fph_d;
         L          <= l_d;
         active_dir <= cur_d;
         phase      <= state_d;
      end
   end

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Random and directed stimulus for a 2-direction and a 3-direction controller,
// checked every cycle against a cycle-count model of the lamp rules.
module tb_traffic_light_controller_n;

   localparam int MIN = 4;
   localparam int MAX = 12;
   localparam int YEL = 5;
   localparam int AR  = 1;
   localparam int FH  = 2;

   typedef struct {
      int ph;
      int cur;
      int nxt;
      int tmr;
      int fph;
   } mdl_t;

   logic       clk, rst, fl2, fl3, chk_en;
   logic [1:0] s2;
   logic [2:0] s3;
   logic [5:0] L2;
   logic [8:0] L3;
   logic       a2;
   logic [1:0] a3;
   logic [1:0] p2, p3;
   int         checks = 0;
   int         passes = 0;
   mdl_t       m2, m3;
   logic [7:0] e;

   traffic_light_controller_n #(
      .N_DIR(2), .MIN_GREEN(MIN), .MAX_GREEN(MAX), .YELLOW_CYC(YEL),
      .ALL_RED_CYC(AR), .FLASH_HALF(FH)
   ) dut2 (
      .clk(clk), .reset(rst), .s(s2), .flash(fl2),
      .L(L2), .active_dir(a2), .phase(p2)
   );

   traffic_light_controller_n #(
      .N_DIR(3), .MIN_GREEN(MIN), .MAX_GREEN(MAX), .YELLOW_CYC(YEL),
      .ALL_RED_CYC(AR), .FLASH_HALF(FH)
   ) dut3 (
      .clk(clk), .reset(rst), .s(s3), .flash(fl3),
      .L(L3), .active_dir(a3), .phase(p3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic mdl_t mreset();
      mdl_t r;
      r.ph = 0; r.cur = 0; r.nxt = 0; r.tmr = 0; r.fph = 0;
      return r;
   endfunction

   // One clock of the lamp rules, counting cycles spent in each phase.
   function automatic mdl_t step(mdl_t m, int n, logic [7:0] sv, logic fl);
      mdl_t r = m;
      bit   other = 0;
      int   first = -1;
      for (int k = 1; k < n; k++) begin
         if (bit'(sv >> ((m.cur + k) % n))) begin
            other = 1;
            if (first < 0) first = (m.cur + k) % n;
         end
      end
      case (m.ph)
         0: begin
            if (fl && m.tmr >= MIN - 1) begin
               r.ph = 1; r.nxt = m.cur; r.tmr = 0;
            end else if (m.tmr >= MIN - 1 && other &&
                         (!bit'(sv >> m.cur) || m.tmr == MAX - 1)) begin
               r.ph = 1; r.nxt = first; r.tmr = 0;
            end else begin
               r.tmr = (m.tmr + 1 < MAX) ? m.tmr + 1 : MAX - 1;
            end
         end
         1: begin
            if (m.tmr + 1 == YEL) begin r.ph = 2; r.tmr = 0; end
            else r.tmr = m.tmr + 1;
         end
         2: begin
            if (m.tmr + 1 == AR) begin
               r.tmr = 0;
               if (fl) begin r.ph = 3; r.fph = 1; end
               else begin r.ph = 0; r.cur = m.nxt; end
            end else r.tmr = m.tmr + 1;
         end
         default: begin
            if (!fl) begin r.ph = 2; r.nxt = m.cur; r.tmr = 0; end
            else if (m.tmr + 1 == FH) begin r.tmr = 0; r.fph = 1 - m.fph; end
            else r.tmr = m.tmr + 1;
         end
      endcase
      return r;
   endfunction

   function automatic logic [23:0] exp_L(mdl_t m, int n);
      logic [23:0] v = '0;
      logic [2:0]  c;
      for (int i = 0; i < n; i++) begin
         case (m.ph)
            0:       c = (i == m.cur) ? 3'b001 : 3'b100;
            1:       c = (i == m.cur) ? 3'b010 : 3'b100;
            2:       c = 3'b100;
            default: c = (m.fph != 0) ? 3'b010 : 3'b000;
         endcase
         v = v | (24'(c) << (3 * i));
      end
      return v;
   endfunction

   function automatic logic [5:0] seq_ho(int k);
      if (k <= 3) return 6'b100_001;
      if (k <= 8) return 6'b100_010;
      if (k == 9) return 6'b100_100;
      return 6'b001_100;
   endfunction

   function automatic logic [7:0] seq_fl(int k);
      if (k <= 3) return {2'd0, 6'b100_001};
      if (k <= 8) return {2'd1, 6'b100_010};
      if (k == 9 || k == 16) return {2'd2, 6'b100_100};
      if (k == 17) return {2'd0, 6'b100_001};
      if (k == 12 || k == 13) return {2'd3, 6'b000_000};
      return {2'd3, 6'b010_010};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m2 <= mreset();
         m3 <= mreset();
      end else begin
         m2 <= step(m2, 2, 8'(s2), fl2);
         m3 <= step(m3, 3, 8'(s3), fl3);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m2_L", 32'(L2), 32'(exp_L(m2, 2)));
         chk("m2_dir", 32'(a2), 32'(m2.cur));
         chk("m2_phase", 32'(p2), 32'(m2.ph));
         chk("m3_L", 32'(L3), 32'(exp_L(m3, 3)));
         chk("m3_dir", 32'(a3), 32'(m3.cur));
         chk("m3_phase", 32'(p3), 32'(m3.ph));
      end
   end

   // Reset pulse between edges; returns 1 time unit after release, still before the next edge.
   task automatic pulse_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1 rst = 1'b1;
      #1;
   endtask

   initial begin
      rst = 1'b0; s2 = '0; s3 = '0; fl2 = 1'b0; fl3 = 1'b0; chk_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_L", 32'(L2), 32'(6'b100_001));
      chk("rst_dir", 32'(a2), 32'(0));
      chk("rst_phase", 32'(p2), 32'(0));
      chk("rst_L3", 32'(L3), 32'(9'b100_100_001));

      s2 = 2'b01;
      #2 rst = 1'b1;
      chk_en = 1'b1;
      repeat (40) begin
         @(negedge clk);
         chk("hold_L", 32'(L2), 32'(6'b100_001));
         chk("hold_phase", 32'(p2), 32'(0));
      end

      s2 = 2'b10;
      pulse_reset();
      chk("ho_L", 32'(L2), 32'(seq_ho(0)));
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         chk("ho_L", 32'(L2), 32'(seq_ho(k)));
      end
      chk("ho_dir", 32'(a2), 32'(1));

      begin
         int run = 0, maxrun = 0, prev = -1, period = -1;
         bit was_green = 1;
         s2 = 2'b11;
         pulse_reset();
         for (int w = 1; w <= 100; w++) begin
            @(negedge clk);
            if (p2 == 2'd0) begin
               if (!was_green && a2 == 1'b0) begin
                  if (prev >= 0) period = w - prev;
                  prev = w;
               end
               run++;
               if (run > maxrun) maxrun = run;
               was_green = 1;
            end else begin
               run = 0;
               was_green = 0;
            end
         end
         chk("alt_maxgreen", 32'(maxrun), 32'(12));
         chk("alt_period", 32'(period), 32'(36));
      end

      s3 = 3'b101;
      pulse_reset();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (p3 == 2'd0 && a3 != 2'd0) break;
      end
      chk("n3_skip", 32'(a3), 32'(2));
      s3 = 3'b011;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (p3 == 2'd0 && a3 != 2'd2) break;
      end
      chk("n3_wrap", 32'(a3), 32'(0));

      s2 = 2'b00; s3 = 3'b000;
      pulse_reset();
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            e = seq_fl(k);
            chk("fl_L", 32'(L2), 32'(e[5:0]));
            chk("fl_phase", 32'(p2), 32'(e[7:6]));
         end
         if (k == 1) fl2 = 1'b1;
         if (k == 15) fl2 = 1'b0;
      end
      chk("fl_dir", 32'(a2), 32'(0));

      s2 = 2'b10;
      pulse_reset();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (p2 == 2'd0 && a2 == 1'b1) break;
      end
      s2 = 2'b01;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (p2 == 2'd1 && a2 == 1'b1) break;
      end
      chk("ar_pre_phase", 32'(p2), 32'(1));
      chk("ar_pre_dir", 32'(a2), 32'(1));
      #2 rst = 1'b0;
      #1;
      chk("ar_L", 32'(L2), 32'(6'b100_001));
      chk("ar_phase", 32'(p2), 32'(0));
      chk("ar_dir", 32'(a2), 32'(0));
      rst = 1'b1;
      #1;
      chk("ar_L_after", 32'(L2), 32'(6'b100_001));

      repeat (3000) begin
         @(negedge clk);
         s2 = 2'($urandom);
         s3 = 3'($urandom);
         if ($urandom_range(0, 99) < 4) fl2 = ~fl2;
         if ($urandom_range(0, 99) < 4) fl3 = ~fl3;
      end
      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
